// File: rtl/icache_dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : Public_Info (package)
//  Brief    : Shared types and default geometry for the direct-mapped I-cache.
//  Revision : 1.0  initial release
// ============================================================================
package Public_Info;

    // Default cache geometry: 64 lines of 4 words (1 KiB of instruction data).
    localparam int c_INDEX_WIDTH = 6;
    localparam int c_LINE_WORDS  = 4;

    // Miss-handling state machine.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MISS_REQ = 2'd1,
        REFILL   = 2'd2,
        REPLAY   = 2'd3
    } icache_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_bank.sv
`default_nettype none
// ============================================================================
//  Module   : icache_bank
//  Brief    : Data/tag storage for the I-cache. Synchronous read of the word
//             at the given offset and of its successor within the same line,
//             plus the line tag; single write port with per-word enables.
//  Revision : 1.0  initial release
// ============================================================================
module icache_bank
    import Public_Info::*;
#(
    parameter int INDEX_WIDTH = c_INDEX_WIDTH,
    parameter int LINE_WORDS  = c_LINE_WORDS
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [INDEX_WIDTH-1:0]                 i_rd_idx,
    input  logic [$clog2(LINE_WORDS)-1:0]          i_rd_off,
    output logic [31:0]                            o_rd_word0,
    output logic [31:0]                            o_rd_word1,
    output logic [31-INDEX_WIDTH-$clog2(LINE_WORDS)-2:0] o_rd_tag,
    input  logic [INDEX_WIDTH-1:0]                 i_wr_idx,
    input  logic [LINE_WORDS-1:0]                  i_wr_be,
    input  logic [31:0]                            i_wr_data,
    input  logic                                   i_tag_we,
    input  logic [31-INDEX_WIDTH-$clog2(LINE_WORDS)-2:0] i_wr_tag
);

    localparam int c_OFF_W = $clog2(LINE_WORDS);
    localparam int c_TAG_W = 32 - INDEX_WIDTH - c_OFF_W - 2;
    localparam int c_LINES = 1 << INDEX_WIDTH;

    logic [31:0]        w_word [LINE_WORDS];
    logic [c_OFF_W-1:0] r_off0;
    logic [c_OFF_W-1:0] w_off1;
    logic [c_TAG_W-1:0] r_tag_mem [c_LINES];
    logic [c_TAG_W-1:0] r_rd_tag;

    // One narrow RAM per word position so a refill beat touches exactly one word.
    for (genvar w = 0; w < LINE_WORDS; w++) begin : g_word
        logic [31:0] r_mem [c_LINES];
        logic [31:0] r_rd;

        // Word write on its byte-lane style enable.
        always_ff @(posedge clk) begin
            if (i_wr_be[w]) begin
                r_mem[i_wr_idx] <= i_wr_data;
            end
        end

        // Registered read of this word position for the addressed line.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_rd <= '0;
            end else begin
                r_rd <= r_mem[i_rd_idx];
            end
        end

        assign w_word[w] = r_rd;
    end

    // Tag write on the final refill beat.
    always_ff @(posedge clk) begin
        if (i_tag_we) begin
            r_tag_mem[i_wr_idx] <= i_wr_tag;
        end
    end

    // Registered tag read and offset, aligned with the word reads.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_tag <= '0;
            r_off0   <= '0;
        end else begin
            r_rd_tag <= r_tag_mem[i_rd_idx];
            r_off0   <= i_rd_off;
        end
    end

    // Second word wraps inside the line; the top level marks it invalid then.
    assign w_off1     = r_off0 + c_OFF_W'(1);
    assign o_rd_word0 = w_word[r_off0];
    assign o_rd_word1 = w_word[w_off1];
    assign o_rd_tag   = r_rd_tag;

endmodule
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : icache_dm
//  Brief    : Direct-mapped instruction cache delivering two sequential
//             instructions per fetch with 1-cycle hit latency. Misses stall
//             the front end, refill a whole line over a burst bus, then
//             replay the held fetch.
//  Revision : 1.0  initial release
// ============================================================================
module icache_dm
    import Public_Info::*;
#(
    parameter int INDEX_WIDTH = c_INDEX_WIDTH,
    parameter int LINE_WORDS  = c_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_pc,
    input  logic        i_req,
    input  logic        flush_BR,
    output logic [31:0] o_IR1,
    output logic [31:0] o_IR2,
    output logic [1:0]  o_is_valid,
    output logic        stall_ICache,
    output logic        mem_rreq,
    output logic [31:0] mem_raddr,
    input  logic        mem_rready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    input  logic        mem_rlast
);

    localparam int c_OFF_W  = $clog2(LINE_WORDS);
    localparam int c_TAG_W  = 32 - INDEX_WIDTH - c_OFF_W - 2;
    localparam int c_LINES  = 1 << INDEX_WIDTH;
    localparam int c_IDX_LO = c_OFF_W + 2;
    localparam int c_TAG_LO = c_IDX_LO + INDEX_WIDTH;
    localparam logic [c_OFF_W-1:0] c_LAST_OFF = c_OFF_W'(LINE_WORDS - 1);

    icache_state_t      r_state;
    icache_state_t      w_state_nxt;
    logic [31:0]        r_pc;
    logic               r_req;
    logic [c_OFF_W-1:0] r_beat;
    logic               r_flush;
    logic [c_LINES-1:0] r_valid;

    logic [c_OFF_W-1:0]     w_off;
    logic [INDEX_WIDTH-1:0] w_idx;
    logic [c_TAG_W-1:0]     w_tag;
    logic [c_OFF_W-1:0]     w_rd_off;
    logic [INDEX_WIDTH-1:0] w_rd_idx;
    logic [c_TAG_W-1:0]     w_rd_tag;
    logic                   w_hit;
    logic                   w_miss_start;
    logic                   w_fill_we;
    logic                   w_fill_last;
    logic [LINE_WORDS-1:0]  w_wr_be;
    logic                   w_unused;

    // Fields of the captured (IF2-stage) fetch address.
    assign w_off    = r_pc[c_IDX_LO-1:2];
    assign w_idx    = r_pc[c_TAG_LO-1:c_IDX_LO];
    assign w_tag    = r_pc[31:c_TAG_LO];
    assign w_unused = ^r_pc[1:0];

    // REPLAY re-reads the array for the held pc; otherwise the array is
    // addressed by the incoming pc so data lines up with the capture register.
    assign w_rd_idx = (r_state == REPLAY) ? w_idx : i_pc[c_TAG_LO-1:c_IDX_LO];
    assign w_rd_off = (r_state == REPLAY) ? w_off : i_pc[c_IDX_LO-1:2];

    assign w_hit = r_req && r_valid[w_idx] && (w_rd_tag == w_tag);

    // Next-state and output decode for the miss FSM.
    always_comb begin
        w_state_nxt  = r_state;
        stall_ICache = 1'b0;
        o_is_valid   = 2'b00;
        mem_rreq     = 1'b0;
        mem_raddr    = '0;
        w_miss_start = 1'b0;
        w_fill_we    = 1'b0;
        w_fill_last  = 1'b0;
        case (r_state)
            IDLE: begin
                // A flush kills the captured request: no output, no miss.
                if (r_req && !flush_BR) begin
                    if (w_hit) begin
                        o_is_valid = {1'b1, (w_off != c_LAST_OFF)};
                    end else begin
                        stall_ICache = 1'b1;
                        w_miss_start = 1'b1;
                        w_state_nxt  = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                stall_ICache = 1'b1;
                mem_rreq     = 1'b1;
                mem_raddr    = {w_tag, w_idx, {(c_OFF_W + 2){1'b0}}};
                if (mem_rready) begin
                    w_state_nxt = REFILL;
                end
            end
            REFILL: begin
                stall_ICache = 1'b1;
                if (mem_rvalid) begin
                    w_fill_we = 1'b1;
                    if (mem_rlast) begin
                        w_fill_last = 1'b1;
                        w_state_nxt = REPLAY;
                    end
                end
            end
            REPLAY: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // One-hot word enable for the current refill beat.
    always_comb begin
        w_wr_be = '0;
        if (w_fill_we) begin
            w_wr_be[r_beat] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture register: loads only in unstalled IDLE so the held pc survives
    // the miss and the replay; a pending flush drops the request at REPLAY.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc  <= '0;
            r_req <= 1'b0;
        end else if (r_state == IDLE && !stall_ICache) begin
            r_pc  <= i_pc;
            r_req <= i_req;
        end else if (r_state == REPLAY && (r_flush || flush_BR)) begin
            r_req <= 1'b0;
        end
    end

    // Refill beat counter, restarted for every new miss and after the last beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat <= '0;
        end else if (w_miss_start) begin
            r_beat <= '0;
        end else if (w_fill_we) begin
            r_beat <= w_fill_last ? '0 : (r_beat + c_OFF_W'(1));
        end
    end

    // Line valid bits: dropped while a line is being overwritten, set on its last beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
        end else if (w_miss_start) begin
            r_valid[w_idx] <= 1'b0;
        end else if (w_fill_last) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    // Sticky flush seen while the bus transaction is in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_flush <= 1'b0;
        end else if (r_state == REPLAY) begin
            r_flush <= 1'b0;
        end else if ((r_state == MISS_REQ || r_state == REFILL) && flush_BR) begin
            r_flush <= 1'b1;
        end
    end

    icache_bank #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .LINE_WORDS  (LINE_WORDS)
    ) u_bank (
        .clk        (clk),
        .rstn       (rstn),
        .i_rd_idx   (w_rd_idx),
        .i_rd_off   (w_rd_off),
        .o_rd_word0 (o_IR1),
        .o_rd_word1 (o_IR2),
        .o_rd_tag   (w_rd_tag),
        .i_wr_idx   (w_idx),
        .i_wr_be    (w_wr_be),
        .i_wr_data  (mem_rdata),
        .i_tag_we   (w_fill_last),
        .i_wr_tag   (w_tag)
    );

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_dm
//  Brief    : Directed self-checking bench for icache_dm with a small bus
//             responder and an output scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_icache_dm;

    logic        clk;
    logic        rstn;
    logic [31:0] i_pc;
    logic        i_req;
    logic        flush_BR;
    logic [31:0] o_IR1;
    logic [31:0] o_IR2;
    logic [1:0]  o_is_valid;
    logic        stall_ICache;
    logic        mem_rreq;
    logic [31:0] mem_raddr;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_rlast;

    typedef struct {
        logic [31:0] ir1;
        logic [31:0] ir2;
        logic [1:0]  vld;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    localparam logic [31:0] c_B = 32'h1C00_0000;

    icache_dm dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_pc         (i_pc),
        .i_req        (i_req),
        .flush_BR     (flush_BR),
        .o_IR1        (o_IR1),
        .o_IR2        (o_IR2),
        .o_is_valid   (o_is_valid),
        .stall_ICache (stall_ICache),
        .mem_rreq     (mem_rreq),
        .mem_raddr    (mem_raddr),
        .mem_rready   (mem_rready),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rlast    (mem_rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing-memory contents: a distinct word per address.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input logic [31:0] ir1, input logic [31:0] ir2, input logic [1:0] vld);
        exp_t e;
        e.ir1 = ir1;
        e.ir2 = ir2;
        e.vld = vld;
        q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"},   {30'd0, o_is_valid}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall_ICache}, 32'd0);
        chk({tag, "_rreq"},  {31'd0, mem_rreq}, 32'd0);
        chk({tag, "_raddr"}, mem_raddr, 32'd0);
        chk({tag, "_ir1"},   o_IR1, 32'd0);
        chk({tag, "_ir2"},   o_IR2, 32'd0);
    endtask

    // One-cycle fetch; returns at the falling edge of the output cycle.
    task automatic fetch(input logic [31:0] pc);
        @(posedge clk); #1;
        i_pc  = pc;
        i_req = 1'b1;
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
    endtask

    // Bus responder: waits for the line request, then streams the line.
    task automatic serve(input logic [31:0] base, input int flush_beat, input int rst_beat);
        int k;
        k = 0;
        while (mem_rreq !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rreq_seen", {31'd0, mem_rreq}, 32'd1);
        chk("raddr", mem_raddr, base);
        chk("stall_missreq", {31'd0, stall_ICache}, 32'd1);
        mem_rready = 1'b1;
        @(posedge clk); #1;
        mem_rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mw(base + 32'(4 * i));
            mem_rlast  = (i == 3);
            flush_BR   = (i == flush_beat);
            if (i == rst_beat) rstn = 1'b0;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rlast  = 1'b0;
            flush_BR   = 1'b0;
            if (i == rst_beat) break;
        end
    endtask

    // REPLAY cycle then output cycle, both without stall.
    task automatic finish_replay(input string tag);
        @(negedge clk);
        chk({tag, "_replay_stall"}, {31'd0, stall_ICache}, 32'd0);
        @(negedge clk);
        chk({tag, "_out_stall"}, {31'd0, stall_ICache}, 32'd0);
    endtask

    // Output monitor: every valid output must match the oldest expectation.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && o_is_valid !== 2'b00) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", {30'd0, o_is_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_vld", {30'd0, o_is_valid}, {30'd0, e.vld});
                    chk("out_ir1", o_IR1, e.ir1);
                    if (e.vld[0]) chk("out_ir2", o_IR2, e.ir2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; i_pc = '0; i_req = 1'b0; flush_BR = 1'b0;
        mem_rready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // Cold miss, full refill, replayed output.
        expect_out(mw(c_B), mw(c_B + 4), 2'b11);
        fetch(c_B);
        chk("miss0_stall", {31'd0, stall_ICache}, 32'd1);
        chk("miss0_vld", {30'd0, o_is_valid}, 32'd0);
        serve(c_B, -1, -1);
        finish_replay("fill0");

        // Hit inside the line.
        expect_out(mw(c_B + 8), mw(c_B + 12), 2'b11);
        fetch(c_B + 8);
        chk("hit8_stall", {31'd0, stall_ICache}, 32'd0);

        // Hit on the last word: second slot invalid.
        expect_out(mw(c_B + 12), 32'd0, 2'b10);
        fetch(c_B + 12);
        chk("hitC_stall", {31'd0, stall_ICache}, 32'd0);
        @(negedge clk);
        chk("noreq_vld", {30'd0, o_is_valid}, 32'd0);

        // Flush during the second refill beat: fill completes, replay silent.
        fetch(c_B + 16);
        chk("miss10_stall", {31'd0, stall_ICache}, 32'd1);
        serve(c_B + 16, 1, -1);
        finish_replay("fill10");
        chk("flushed_replay_vld", {30'd0, o_is_valid}, 32'd0);
        expect_out(mw(c_B + 16), mw(c_B + 20), 2'b11);
        fetch(c_B + 16);
        chk("hit10_stall", {31'd0, stall_ICache}, 32'd0);

        // Flush in IDLE kills the captured hit.
        @(posedge clk); #1;
        i_pc = c_B + 16; i_req = 1'b1;
        @(posedge clk); #1;
        i_req = 1'b0; flush_BR = 1'b1;
        @(negedge clk);
        chk("idleflush_vld", {30'd0, o_is_valid}, 32'd0);
        chk("idleflush_stall", {31'd0, stall_ICache}, 32'd0);
        @(posedge clk); #1;
        flush_BR = 1'b0;
        @(negedge clk);
        chk("idleflush_norreq", {31'd0, mem_rreq}, 32'd0);

        // Conflict miss: same index, other tag, then the original misses again.
        expect_out(mw(c_B + 32'h400), mw(c_B + 32'h404), 2'b11);
        fetch(c_B + 32'h400);
        chk("miss400_stall", {31'd0, stall_ICache}, 32'd1);
        serve(c_B + 32'h400, -1, -1);
        finish_replay("fill400");
        expect_out(mw(c_B), mw(c_B + 4), 2'b11);
        fetch(c_B);
        chk("remiss0_stall", {31'd0, stall_ICache}, 32'd1);
        serve(c_B, -1, -1);
        finish_replay("refill0");

        // A stray beat in IDLE changes nothing.
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rlast = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rlast = 1'b0;
        @(negedge clk);
        chk("stray_stall", {31'd0, stall_ICache}, 32'd0);
        expect_out(mw(c_B + 4), mw(c_B + 8), 2'b11);
        fetch(c_B + 4);
        chk("hit4_stall", {31'd0, stall_ICache}, 32'd0);

        // Reset on the third beat abandons the refill and clears all lines.
        fetch(c_B + 32);
        chk("miss20_stall", {31'd0, stall_ICache}, 32'd1);
        serve(c_B + 32, -1, 2);
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk_all_zero("postrst");
        expect_out(mw(c_B), mw(c_B + 4), 2'b11);
        fetch(c_B);
        chk("postrst_miss", {31'd0, stall_ICache}, 32'd1);
        serve(c_B, -1, -1);
        finish_replay("postrst_fill");

        @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 The parameter INDEX_WIDTH SHALL default to 6 and set the number of lines to 2^INDEX_WIDTH.
REQ-002 The parameter LINE_WORDS SHALL default to 4 and set the number of 32-bit words per line (power of two, at least 2).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, as listed below.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 i_pc  input  32  fetch address from IF1; word-aligned.
REQ-007 i_req  input  1  fetch request valid this cycle.
REQ-008 flush_BR  input  1  branch-mispredict flush.
REQ-009 o_IR1  output  32  instruction at the captured pc.
REQ-010 o_IR2  output  32  instruction at the captured pc+4.
REQ-011 o_is_valid  output  2  bit1 = o_IR1 valid, bit0 = o_IR2 valid.
REQ-012 stall_ICache  output  1  miss in progress; freezes IF1 and IF1_IF2.
REQ-013 mem_rreq  output  1  line-read request to the memory bus.
REQ-014 mem_raddr  output  32  line-aligned refill address.
REQ-015 mem_rready  input  1  bus has accepted the request.
REQ-016 mem_rdata  input  32  refill beat data.
REQ-017 mem_rvalid  input  1  refill beat valid.
REQ-018 mem_rlast  input  1  final refill beat.

Function
REQ-019 The block SHALL register i_pc and i_req when stall_ICache is 0, giving a 1-cycle hit latency (pc in cycle N, data in cycle N+1), matching synchronous-BRAM timing.
REQ-020 Address split: offset = i_pc[log2(LINE_WORDS)+1:2]; index = next INDEX_WIDTH bits; tag = the remaining upper bits.
REQ-021 A hit requires that the captured line's valid bit is set and its stored tag equals the captured tag.
REQ-022 On a hit, o_is_valid[1] SHALL be 1, and o_is_valid[0] SHALL be 1 only if pc+4 lies in the same line (offset not equal to LINE_WORDS-1).
REQ-023 The FSM SHALL have the states IDLE, MISS_REQ, REFILL and REPLAY.
REQ-024 IDLE -> MISS_REQ when the captured request misses; stall_ICache SHALL be driven combinationally high in that same cycle, and o_is_valid SHALL be 00.
REQ-025 In MISS_REQ, mem_rreq SHALL be 1 and mem_raddr = {tag, index, zero offset}; the FSM SHALL move to REFILL when mem_rready = 1.
REQ-026 In REFILL, each mem_rvalid beat SHALL write the word at a beat counter that starts at 0; the beat with mem_rlast = 1 SHALL write the tag and set the valid bit, and the FSM SHALL move to REPLAY.
REQ-027 In REPLAY, the block SHALL re-read the array for the held pc, drop stall_ICache, present hit data the next cycle, and return to IDLE.
REQ-028 stall_ICache SHALL be 1 in MISS_REQ, in REFILL, and in the IDLE-miss cycle; it SHALL be 0 otherwise.
REQ-029 flush_BR in IDLE SHALL force o_is_valid to 00 for the current output cycle and SHALL invalidate the captured request.
REQ-030 flush_BR during MISS_REQ or REFILL SHALL NOT abort the bus transaction; the line SHALL still be filled, the FSM SHALL go from REPLAY to IDLE without producing valid output, and the flush SHALL be held in a sticky flag until REPLAY.
REQ-031 A mem_rvalid beat outside REFILL SHALL be ignored.
REQ-032 If mem_rlast arrives before LINE_WORDS beats, the line SHALL still be marked valid; words not yet written are undefined, and this is a bus protocol error.
REQ-033 When i_req = 0, o_is_valid SHALL be 00 in the following cycle.

Reset
REQ-034 While rstn = 0: FSM = IDLE, all line valid bits = 0, captured request = invalid, beat counter = 0, flush flag = 0.
REQ-035 While rstn = 0: o_is_valid = 00, stall_ICache = 0, mem_rreq = 0, mem_raddr = 0, o_IR1 = o_IR2 = 0.
REQ-036 Reset asserted mid-refill SHALL abandon the transaction, leaving no line valid.

Structure
REQ-037 The state enum icache_state_t and the default constants for INDEX_WIDTH and LINE_WORDS SHALL live in the shared Public_Info package.
REQ-038 The data/tag storage SHALL be one sub-module, icache_bank: a dual-read, single-write synchronous array with per-word write enable.
REQ-039 The FSM, the hit logic and the beat counter SHALL reside in icache_dm.

Verification
REQ-040 After reset, i_pc = 0x1C000000 with i_req = 1 -> miss; stall_ICache = 1; mem_raddr = 0x1C000000; after 4 beats and REPLAY, o_IR1/o_IR2 = beats 0/1 and o_is_valid = 11.
REQ-041 A repeat fetch of 0x1C000008 -> hit one cycle later with no stall, o_IR1/o_IR2 = beats 2/3, o_is_valid = 11.
REQ-042 A fetch of 0x1C00000C after the fill -> o_is_valid = 10 (line boundary), o_IR1 = beat 3.
REQ-043 flush_BR pulsed during the 2nd refill beat -> the line becomes valid, the REPLAY output has o_is_valid = 00, and a later fetch of the same address hits.
REQ-044 0x1C000000 then 0x1C000400 (same index, different tag) -> second fetch misses and refills, and a re-fetch of 0x1C000000 misses again.
REQ-045 rstn dropped during the 3rd beat -> on reset release all outputs are 0, and a fetch of 0x1C000000 misses.
